// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave backed by a word-addressed RAM: classic cycles, registered-feedback
// bursts (constant / incrementing with linear or wrap-4/8/16), wait states, error responses.
module wb_mem_responder #(
  parameter int              AW          = 32,
  parameter int              DEPTH       = 256,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [IW-1:0] idx, idx_d, req_idx, next_idx, load_idx, wrap_mask;
  logic          load, mem_we, valid, hit, burst, overrun;
  logic [AW:0]   diff;
  logic [31:0]   mem [DEPTH];

  // Handshake: a beat is offered while cyc&stb; it completes on the edge ending a cycle
  // with ack or err high. Dropping cyc or stb before that abandons the beat.
  assign valid   = wb_cyc_i & wb_stb_i;
  assign diff    = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign hit     = !diff[AW] && (diff[AW-1:IW+2] == '0) && (diff[1:0] == 2'b00);
  assign req_idx = diff[IW+1:2];
  assign burst   = (WAIT_STATES == 0) && (wb_cti_i == 3'b001 || wb_cti_i == 3'b010);
  assign overrun = (wb_cti_i == 3'b010) && (wb_bte_i == 2'b00) && (idx == IW'(DEPTH - 1));

  always_comb begin
    wrap_mask = '0;
    case (wb_bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '0;
    endcase
  end

  // Constant-address bursts re-read the same word; wrapping bursts stay in their block.
  always_comb begin
    next_idx = idx;
    if (wb_cti_i == 3'b010) begin
      if (wb_bte_i == 2'b00) next_idx = idx + IW'(1);
      else                   next_idx = (idx & ~wrap_mask) | ((idx + IW'(1)) & wrap_mask);
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    load     = 1'b0;
    load_idx = idx;
    mem_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (hit) begin
            idx_d = req_idx;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
              state_d  = S_ACK;
              load     = 1'b1;
              load_idx = req_idx;
            end
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WAIT: begin
        if (!valid) begin
          state_d = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_d  = S_ACK;
          load     = 1'b1;
          load_idx = idx;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (valid) begin
          mem_we = wb_we_i;
          if (burst) begin
            if (overrun) begin
              state_d = S_ERR;
            end else begin
              state_d  = S_ACK;
              idx_d    = next_idx;
              load     = 1'b1;
              load_idx = next_idx;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx      <= '0;
      wb_dat_o <= 32'h0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      if (load) wb_dat_o <= mem[load_idx];
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = (state == S_ACK);
  assign wb_err_o = (state == S_ERR);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: a zero-wait instance and a three-wait instance
// share one master; responses are checked against a queue of expected beats.
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        we, cyc0, cyc1, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat0, dat1;
  logic        ack0, err0, ack1, err1;

  int          tests = 0;
  int          fails = 0;
  logic [33:0] exp_q[$];  // {check_data, expect_err, data}

  logic [31:0] b_adr[16];
  logic [31:0] b_dat[16];
  logic [3:0]  b_sel[16];
  logic [2:0]  b_cti[16];
  int          b_lat[16];
  logic [31:0] model[16];

  always #5 clk = ~clk;

  wb_mem_responder #(.WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0)
  );

  wb_mem_responder #(.WAIT_STATES(3)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1)
  );

  function automatic logic ack_of(input int d);
    return (d == 1) ? ack1 : ack0;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 1) ? err1 : err0;
  endfunction
  function automatic logic [31:0] dat_of(input int d);
    return (d == 1) ? dat1 : dat0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_wr();
    exp_q.push_back({1'b0, 1'b0, 32'h0});
  endtask
  task automatic push_rd(input logic [31:0] d);
    exp_q.push_back({1'b1, 1'b0, d});
  endtask
  task automatic push_err();
    exp_q.push_back({1'b0, 1'b1, 32'h0});
  endtask

  // Drives n beats from the b_* tables to instance d and scores each response.
  task automatic run(input int d, input int n, input logic w, input logic [1:0] e);
    logic        got, saw_err;
    logic [33:0] ex;
    int          lat;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      adr = b_adr[k]; dat_w = b_dat[k]; sel = b_sel[k]; cti = b_cti[k];
      bte = e; we = w; stb = 1'b1; cyc0 = (d == 0); cyc1 = (d == 1);
      got = 1'b0; lat = 0;
      while (!got && lat < 40) begin
        @(negedge clk);
        lat++;
        got = ack_of(d) | err_of(d);
      end
      b_lat[k] = lat;
      if (!got || exp_q.size() == 0) begin
        tests++; fails++;
        $error("FAIL beat_response: beat %0d got %0d queued %0d", k, got, exp_q.size());
        break;
      end
      ex = exp_q.pop_front();
      saw_err = err_of(d);
      check("resp_err", 32'(saw_err), 32'(ex[32]));
      check("ack_and_err", 32'(ack_of(d) & err_of(d)), 32'h0);
      if (ex[33]) check("rd_data", dat_of(d), ex[31:0]);
      @(posedge clk); #1;
      if (saw_err) break;
    end
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    check("idle_ack", 32'(ack_of(d)), 32'h0);
    check("idle_err", 32'(err_of(d)), 32'h0);
  endtask

  task automatic single(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] s);
    b_adr[0] = a; b_dat[0] = data; b_sel[0] = s; b_cti[0] = 3'b000;
    run(d, 1, w, 2'b00);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data,
                    input logic [3:0] s);
    push_wr();
    single(d, 1'b1, a, data, s);
    check("wr_latency", 32'(b_lat[0]), (d == 1) ? 32'd5 : 32'd2);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] expd);
    push_rd(expd);
    single(d, 1'b0, a, 32'h0, 4'hF);
    check("rd_latency", 32'(b_lat[0]), (d == 1) ? 32'd5 : 32'd2);
  endtask

  task automatic rd_err(input int d, input logic [31:0] a);
    push_err();
    single(d, 1'b0, a, 32'h0, 4'hF);
    check("err_latency", 32'(b_lat[0]), 32'd2);
  endtask

  task automatic set_beat(input int k, input logic [31:0] a, input logic [31:0] data,
                          input logic [2:0] c);
    b_adr[k] = a; b_dat[k] = data; b_sel[k] = 4'hF; b_cti[k] = c;
  endtask

  initial begin
    logic [31:0] rv;
    logic [3:0]  rs;
    int          ri;

    rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0;
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    repeat (3) @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'h0);
    check("rst_err0", 32'(err0), 32'h0);
    check("rst_dat0", dat0, 32'h0);
    check("rst_ack1", 32'(ack1), 32'h0);
    check("rst_err1", 32'(err1), 32'h0);
    check("rst_dat1", dat1, 32'h0);
    rst_n = 1'b1;

    // Classic write/read and a byte-lane merge
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd(0, 32'h10, 32'hDEADBEEF);
    wr(0, 32'h20, 32'h11223344, 4'hF);
    wr(0, 32'h20, 32'h000000AA, 4'b0001);
    rd(0, 32'h20, 32'h112233AA);

    // Incrementing linear burst, write then read
    for (int k = 0; k < 4; k++) begin
      set_beat(k, 32'h40 + 32'(4 * k), 32'(k + 1), (k == 3) ? 3'b111 : 3'b010);
      push_wr();
    end
    run(0, 4, 1'b1, 2'b00);
    for (int k = 0; k < 4; k++) check("wburst_lat", 32'(b_lat[k]), (k == 0) ? 32'd2 : 32'd1);
    for (int k = 0; k < 4; k++) push_rd(32'(k + 1));
    run(0, 4, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) check("rburst_lat", 32'(b_lat[k]), (k == 0) ? 32'd2 : 32'd1);

    // Wrap-4 read starting mid-block
    set_beat(0, 32'h40, 32'hA0A0A0A0, 3'b010);
    set_beat(1, 32'h44, 32'hB1B1B1B1, 3'b010);
    set_beat(2, 32'h48, 32'hC2C2C2C2, 3'b010);
    set_beat(3, 32'h4C, 32'hD3D3D3D3, 3'b111);
    for (int k = 0; k < 4; k++) push_wr();
    run(0, 4, 1'b1, 2'b00);
    set_beat(0, 32'h48, 32'h0, 3'b010);
    set_beat(1, 32'h4C, 32'h0, 3'b010);
    set_beat(2, 32'h40, 32'h0, 3'b010);
    set_beat(3, 32'h44, 32'h0, 3'b111);
    push_rd(32'hC2C2C2C2); push_rd(32'hD3D3D3D3); push_rd(32'hA0A0A0A0); push_rd(32'hB1B1B1B1);
    run(0, 4, 1'b0, 2'b01);
    for (int k = 1; k < 4; k++) check("wrap_lat", 32'(b_lat[k]), 32'd1);

    // Constant-address burst
    for (int k = 0; k < 3; k++) begin
      set_beat(k, 32'h10, 32'h0, (k == 2) ? 3'b111 : 3'b001);
      push_rd(32'hDEADBEEF);
    end
    run(0, 3, 1'b0, 2'b00);
    check("const_lat", 32'(b_lat[2]), 32'd1);

    // Linear burst running off the last word
    wr(0, 32'h3FC, 32'h55AA55AA, 4'hF);
    set_beat(0, 32'h3FC, 32'h0, 3'b010);
    set_beat(1, 32'h400, 32'h0, 3'b111);
    push_rd(32'h55AA55AA); push_err();
    run(0, 2, 1'b0, 2'b00);
    check("overrun_lat", 32'(b_lat[1]), 32'd1);

    // Randomised partial writes against a local word model
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      wr(0, 32'h200 + 32'(4 * i), model[i], 4'hF);
    end
    for (int n = 0; n < 20; n++) begin
      ri = $urandom_range(0, 15);
      rs = 4'($urandom_range(1, 15));
      rv = $urandom;
      for (int b = 0; b < 4; b++) if (rs[b]) model[ri][8*b +: 8] = rv[8*b +: 8];
      wr(0, 32'h200 + 32'(4 * ri), rv, rs);
    end
    for (int i = 0; i < 16; i++) rd(0, 32'h200 + 32'(4 * i), model[i]);

    // Three wait states: singles, burst beats as singles, decode errors
    wr(1, 32'h0, 32'h0BADF00D, 4'hF);
    wr(1, 32'h4, 32'h12345678, 4'hF);
    rd(1, 32'h0, 32'h0BADF00D);
    set_beat(0, 32'h0, 32'h0, 3'b010);
    set_beat(1, 32'h4, 32'h0, 3'b111);
    push_rd(32'h0BADF00D); push_rd(32'h12345678);
    run(1, 2, 1'b0, 2'b00);
    check("ws_burst_lat0", 32'(b_lat[0]), 32'd5);
    check("ws_burst_lat1", 32'(b_lat[1]), 32'd5);
    rd_err(1, 32'h400);
    rd_err(1, 32'h2);

    // Abort during WAIT: the write must not land
    wr(1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    adr = 32'h30; dat_w = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cti = 3'b000; stb = 1'b1; cyc1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_wait_ack", 32'(ack1), 32'h0);
      check("abort_wait_err", 32'(err1), 32'h0);
    end
    @(posedge clk); #1;
    cyc1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_after_ack", 32'(ack1), 32'h0);
      check("abort_after_err", 32'(err1), 32'h0);
    end
    stb = 1'b0; we = 1'b0;
    rd(1, 32'h30, 32'hCAFEF00D);

    // Reset asserted during the second beat of a write burst
    for (int k = 0; k < 4; k++) begin
      set_beat(k, 32'h60 + 32'(4 * k), 32'h6000_0000 + 32'(k), (k == 3) ? 3'b111 : 3'b010);
      push_wr();
    end
    run(0, 4, 1'b1, 2'b00);
    @(posedge clk); #1;
    adr = 32'h60; dat_w = 32'hABCD0000; sel = 4'hF; we = 1'b1; cti = 3'b010; bte = 2'b00;
    stb = 1'b1; cyc0 = 1'b1;
    @(negedge clk);
    check("rb_c0_ack", 32'(ack0), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_c1_ack", 32'(ack0), 32'h1);
    @(posedge clk); #1;
    adr = 32'h64; dat_w = 32'hABCD0001;
    @(negedge clk);
    check("rb_c2_ack", 32'(ack0), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rb_ack0", 32'(ack0), 32'h0);
    check("rb_err0", 32'(err0), 32'h0);
    check("rb_dat0", dat0, 32'h0);
    check("rb_ack1", 32'(ack1), 32'h0);
    check("rb_err1", 32'(err1), 32'h0);
    check("rb_dat1", dat1, 32'h0);
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_ack", 32'(ack0), 32'h0);
      check("post_rst_err", 32'(err0), 32'h0);
    end
    rd(0, 32'h60, 32'hABCD0000);
    rd(0, 32'h64, 32'h60000001);
    rd(0, 32'h68, 32'h60000002);

    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
